// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs the req/gnt/rvalid handshake with data memory,
// stalls the pipeline until the access retires and presents the extended load word.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [31:0]       alu_MEM_in,
   input  logic [31:0]       store_data,
   output logic [31:0]       load_data,
   output logic              mem_stall,
   output logic              mem_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: dmem_req stays high with address/we/be/wdata stable until the
   // cycle dmem_gnt is seen; the request transfers on that cycle. dmem_rvalid
   // only carries meaning while a load waits for its response.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        start;
   logic        is_load;
   logic        f3_legal;
   logic        aligned;
   logic        acc_ok;
   logic        accept;
   logic [1:0]  off;
   logic [3:0]  be_enc;
   logic [31:0] wdata_enc;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // A load wins when both MemRead and MemWrite are set.
   assign start   = mem_valid & (MemRead | MemWrite);
   assign is_load = MemRead;
   assign off     = alu_MEM_in[1:0];

   always_comb begin
      f3_legal = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = is_load;
         default:                f3_legal = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b1;
      case (funct3[1:0])
         2'b01:   aligned = ~off[0];
         2'b10:   aligned = (off == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   assign acc_ok = f3_legal & aligned;
   assign accept = (state_q == S_IDLE) & start & acc_ok;

   always_comb begin
      be_enc    = 4'b1111;
      wdata_enc = store_data;
      case (funct3[1:0])
         2'b00: begin
            be_enc    = 4'b0001 << off;
            wdata_enc = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_enc    = 4'b0011 << off;
            wdata_enc = {2{store_data[15:0]}};
         end
         default: begin
            be_enc    = 4'b1111;
            wdata_enc = store_data;
         end
      endcase
   end

   // Extraction works on the registered offset/size, not the live pipeline inputs.
   assign byte_sel = 8'(dmem_rdata >> {off_q, 3'b000});
   assign half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      load_ext = dmem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mem_stall = 1'b0;
      mem_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (acc_ok) begin
                  mem_stall = 1'b1;
                  state_d   = S_REQ;
               end else begin
                  mem_err = 1'b1;
               end
            end
         end
         S_REQ: begin
            dmem_req  = 1'b1;
            dmem_we   = we_q;
            mem_stall = 1'b1;
            if (dmem_gnt) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            mem_stall = 1'b1;
            if (dmem_rvalid) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_addr  <= '0;
         dmem_be    <= 4'b0000;
         dmem_wdata <= 32'd0;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
      end else if (accept) begin
         dmem_addr  <= {alu_MEM_in[ADDR_W-1:2], 2'b00};
         dmem_be    <= is_load ? 4'b0000 : be_enc;
         dmem_wdata <= is_load ? 32'd0 : wdata_enc;
         we_q       <= ~is_load;
         f3_q       <= funct3;
         off_q      <= off;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_data <= 32'd0;
      end else if ((state_q == S_WAIT) && dmem_rvalid) begin
         load_data <= load_ext;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses checked
// against a plain arithmetic model of load extraction, store encoding and timing.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] alu_MEM_in;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        mem_stall;
   logic        mem_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [1:0]  dbg_state;

   int          n_vec;
   int          n_err;
   logic [31:0] model_ld;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_valid   (mem_valid),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .funct3      (funct3),
      .alu_MEM_in  (alu_MEM_in),
      .store_data  (store_data),
      .load_data   (load_data),
      .mem_stall   (mem_stall),
      .mem_err     (mem_err),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = (rd >> (8 * off)) & 32'hFF;
      h = (rd >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'd0:    return 4'(1 << off);
         3'd1:    return 4'(3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] sd);
      case (f3)
         3'd0:    return {4{sd[7:0]}};
         3'd1:    return {2{sd[15:0]}};
         default: return sd;
      endcase
   endfunction

   function automatic bit ref_ok(input bit ld, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      int size;
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      size  = 1 << f3[1:0];
      return legal && ((a % size) == 0);
   endfunction

   // driver: one full access, checked cycle by cycle; gd = gnt delay, rd = rvalid delay
   task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input int gd, input int rd,
                             input logic [31:0] rdat, input string name);
      int n_req;
      int total;
      bit in_req;
      bit in_wait;
      n_req = gd + 1;
      total = 1 + n_req + (ld ? rd + 1 : 0);
      for (int c = 0; c <= total; c++) begin
         @(negedge clk);
         in_req  = (c >= 1) && (c <= n_req);
         in_wait = ld && (c > n_req) && (c < total);
         if (c == 0) begin
            mem_valid  = 1'b1;
            MemRead    = ld;
            MemWrite   = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            funct3     = f3;
            alu_MEM_in = addr;
            store_data = sd;
         end else if (c == total) begin
            // a legal start offered in DONE must be ignored
            mem_valid  = 1'b1;
            MemRead    = 1'b1;
            MemWrite   = 1'b0;
            funct3     = 3'd2;
            alu_MEM_in = $urandom & 32'hFFFFFFFC;
            store_data = $urandom;
         end else begin
            mem_valid  = 1'b0;
            MemRead    = 1'($urandom_range(0, 1));
            MemWrite   = 1'($urandom_range(0, 1));
            funct3     = 3'($urandom_range(0, 7));
            alu_MEM_in = $urandom;
            store_data = $urandom;
         end
         dmem_gnt    = in_req ? (c == n_req) : 1'($urandom_range(0, 1));
         dmem_rvalid = in_wait ? (c == total - 1) : (in_req ? 1'($urandom_range(0, 1)) : 1'b0);
         dmem_rdata  = (in_wait && c == total - 1) ? rdat : $urandom;
         #1;
         n_vec++;
         if (mem_stall !== (c < total)) begin
            n_err++;
            $display("FAIL %s stall c=%0d got=%0b want=%0b", name, c, mem_stall, (c < total));
         end
         n_vec++;
         if (dmem_req !== in_req || mem_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s req/err c=%0d req=%0b err=%0b want req=%0b err=0", name, c,
                     dmem_req, mem_err, in_req);
         end
         if (in_req) begin
            n_vec++;
            if (dmem_we !== !ld || dmem_addr !== (addr & 32'hFFFFFFFC) ||
                dmem_be !== (ld ? 4'h0 : ref_be(f3, addr[1:0]))) begin
               n_err++;
               $display("FAIL %s req_fields c=%0d we=%0b addr=%h be=%b want we=%0b addr=%h be=%b",
                        name, c, dmem_we, dmem_addr, dmem_be, !ld, addr & 32'hFFFFFFFC,
                        ld ? 4'h0 : ref_be(f3, addr[1:0]));
            end
            if (!ld) begin
               n_vec++;
               if (dmem_wdata !== ref_wd(f3, sd)) begin
                  n_err++;
                  $display("FAIL %s wdata got=%h want=%h", name, dmem_wdata, ref_wd(f3, sd));
               end
            end
         end
         if (c == total) begin
            if (ld) model_ld = ref_load(f3, addr[1:0], rdat);
            n_vec++;
            if (load_data !== model_ld) begin
               n_err++;
               $display("FAIL %s load_data got=%h want=%h", name, load_data, model_ld);
            end
         end
      end
      @(negedge clk);
      mem_valid   = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic run_err(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input string name);
      @(negedge clk);
      mem_valid  = 1'b1;
      MemRead    = ld;
      MemWrite   = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      funct3     = f3;
      alu_MEM_in = addr;
      store_data = $urandom;
      dmem_gnt   = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (mem_err !== 1'b1 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL %s pulse err=%0b stall=%0b req=%0b want 1/0/0", name, mem_err,
                  mem_stall, dmem_req);
      end
      @(negedge clk);
      mem_valid = 1'b0;
      dmem_gnt  = 1'b0;
      #1;
      n_vec++;
      if (mem_err !== 1'b0 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL %s after err=%0b stall=%0b req=%0b want 0/0/0", name, mem_err,
                  mem_stall, dmem_req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({load_data, dmem_addr, dmem_wdata, dmem_be, dmem_req, dmem_we, mem_stall, mem_err,
           dbg_state} !== '0) begin
         n_err++;
         $display("FAIL reset ld=%h addr=%h wd=%h be=%b req=%0b we=%0b stall=%0b err=%0b st=%0d want all 0",
                  load_data, dmem_addr, dmem_wdata, dmem_be, dmem_req, dmem_we, mem_stall,
                  mem_err, dbg_state);
      end
      @(negedge clk);
      rst = 1'b1;
      model_ld = 32'd0;
   endtask

   task automatic test_loads();
      run_access(1'b1, 3'd2, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, "lw_0x100");
      run_access(1'b1, 3'd0, 32'h103, 32'd0, 0, 0, 32'h80AABBCC, "lb_0x103");
      n_vec++;
      if (load_data !== 32'hFFFFFF80) begin
         n_err++;
         $display("FAIL lb_value got=%h want=%h", load_data, 32'hFFFFFF80);
      end
      run_access(1'b1, 3'd4, 32'h103, 32'd0, 1, 2, 32'h80AABBCC, "lbu_0x103");
      n_vec++;
      if (load_data !== 32'h00000080) begin
         n_err++;
         $display("FAIL lbu_value got=%h want=%h", load_data, 32'h00000080);
      end
   endtask

   task automatic test_store_delayed_gnt();
      run_access(1'b0, 3'd1, 32'h202, 32'h1234ABCD, 3, 0, 32'd0, "sh_0x202");
   endtask

   task automatic test_errors();
      run_err(1'b1, 3'd2, 32'h101, "lw_0x101");
      run_err(1'b0, 3'd1, 32'h001, "sh_0x001");
      run_err(1'b0, 3'd4, 32'h000, "store_f3_100");
      run_err(1'b1, 3'd3, 32'h000, "load_f3_011");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2;
      alu_MEM_in = 32'h440;
      @(negedge clk);
      mem_valid = 1'b0; dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      rst = 1'b0;
      #1;
      model_ld = 32'd0;
      n_vec++;
      if ({load_data, dmem_addr, dmem_wdata, dmem_be, dmem_req, dmem_we, mem_stall, mem_err,
           dbg_state} !== '0) begin
         n_err++;
         $display("FAIL reset_mid ld=%h addr=%h req=%0b stall=%0b st=%0d want all 0",
                  load_data, dmem_addr, dmem_req, mem_stall, dbg_state);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFEF00D;
      #1;
      n_vec++;
      if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL late_rvalid stall=%0b req=%0b want 0/0", mem_stall, dmem_req);
      end
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1;
      n_vec++;
      if (load_data !== 32'd0 || dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL late_rvalid_ld got=%h st=%0d want 0 / 0", load_data, dbg_state);
      end
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 3'd2, 32'h300, 32'h55AA1234, 0, 0, 32'd0, "b2b_sw");
      run_access(1'b1, 3'd5, 32'h302, 32'd0, 0, 0, 32'hF00D0000, "b2b_lhu");
      n_vec++;
      if (load_data !== 32'h0000F00D) begin
         n_err++;
         $display("FAIL lhu_value got=%h want=%h", load_data, 32'h0000F00D);
      end
   endtask

   task automatic test_random();
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;
      for (int i = 0; i < 40; i++) begin
         ld = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            k = ld ? $urandom_range(0, 4) : $urandom_range(0, 2);
            case (k)
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
            a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         end
         if (ref_ok(ld, f3, a))
            run_access(ld, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom, "rand");
         else
            run_err(ld, f3, a, "rand_err");
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; model_ld = 32'd0;
      mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
      alu_MEM_in = 32'd0; store_data = 32'd0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      test_reset();
      test_loads();
      test_store_delayed_gnt();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
